// File: rtl/gray_packer.sv
// =====================================================================
//  gray_packer : packs replicated-gray pixels into 4x8-bit words,
//                zero-flushing the final partial word of every frame.
//  Revision    : 1.0
// =====================================================================
`default_nettype none

module gray_packer #(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int FRAME_PIXELS    = 442368
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       fifo_in_rd_en,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_in_dout,
    input  logic                       fifo_in_empty,
    output logic                       fifo_out_wr_en,
    output logic [FIFO_DATA_WIDTH-1:0] fifo_out_din,
    input  logic                       fifo_out_full,
    output logic                       frame_done,
    output logic                       chan_err
);

    localparam int                CNT_W    = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_PIXELS - 1);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t             state_q;
    logic [31:0]        word_q;
    logic [1:0]         lane_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_q;
    logic               frame_done_q;
    logic               chan_err_q;

    logic               w_pop;
    logic               w_push;
    logic [7:0]         w_gray;
    logic               w_mismatch;
    logic               w_cnt_last;

    // Handshakes are gated by reset so every output reads 0 while it is held.
    assign w_pop      = (state_q == S_FILL)  && !fifo_in_empty && !reset;
    assign w_push     = (state_q == S_WRITE) && !fifo_out_full && !reset;
    assign w_gray     = fifo_in_dout[7:0];
    assign w_mismatch = (fifo_in_dout[23:16] != fifo_in_dout[15:8]) ||
                        (fifo_in_dout[15:8]  != fifo_in_dout[7:0]);
    assign w_cnt_last = (cnt_q == CNT_LAST);

    generate
        if (FIFO_DATA_WIDTH > 24) begin : g_unused_hi
            logic unused_dout_hi;
            assign unused_dout_hi = ^fifo_in_dout[FIFO_DATA_WIDTH-1:24];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_FILL;
            word_q       <= '0;
            lane_q       <= '0;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            chan_err_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (w_pop) begin
                word_q[{lane_q, 3'b000} +: 8] <= w_gray;
                cnt_q  <= w_cnt_last ? '0 : cnt_q + 1'b1;
                last_q <= w_cnt_last;
                if (w_mismatch) begin
                    chan_err_q <= 1'b1;
                end
                if ((lane_q == 2'd3) || w_cnt_last) begin
                    state_q <= S_WRITE;
                end else begin
                    lane_q <= lane_q + 2'd1;
                end
            end
            if (w_push) begin
                // last_q remembers whether this word carried the frame's final pixel.
                frame_done_q <= last_q;
                last_q       <= 1'b0;
                word_q       <= '0;
                lane_q       <= '0;
                state_q      <= S_FILL;
            end
        end
    end

    assign fifo_in_rd_en  = w_pop;
    assign fifo_out_wr_en = w_push;
    assign fifo_out_din   = FIFO_DATA_WIDTH'(word_q);
    assign frame_done     = frame_done_q;
    assign chan_err       = chan_err_q;

endmodule

`default_nettype wire
